// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed seven-segment driver: latches a BCD word on a strobe and
// scans units, blank, tens, blank, flagging any nibble above 9.

module bcd_7seg_enc (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Active-high {g,f,e,d,c,b,a}; anything past 9 shows a dash.
  always_comb begin
    seg = 7'h40;
    case (nib)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h40;
    endcase
  end
endmodule

module bcd_7seg_scan #(
  parameter int DIGIT_CYCLES   = 4,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLANK_LZ       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd,
  input  logic       bcd_valid,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err,
  output logic       frame_tick
);
  localparam int NUM_DIGITS = 2;
  localparam int MAXLEN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {SHOW_UNITS, BLANK_A, SHOW_TENS, BLANK_B} state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [CW-1:0]                      last;
  logic [7:0]                         disp_reg;
  logic [NUM_DIGITS-1:0][3:0]         dig;
  logic [NUM_DIGITS-1:0][6:0]         enc;
  logic [NUM_DIGITS-1:0]              nib_bad;
  logic [6:0]                         seg_ah;

  assign dig = disp_reg;

  // One encoder per digit so the lit digit is a pure mux of precomputed codes.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_7seg_enc u_enc (.nib(dig[g]), .seg(enc[g]));
    assign nib_bad[g] = (dig[g] > 4'd9);
  end

  always_comb begin
    last = CW'(BLANK_CYCLES - 1);
    if (state == SHOW_UNITS || state == SHOW_TENS)
      last = CW'(DIGIT_CYCLES - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg   <= 8'h00;
      state      <= BLANK_B;
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (bcd_valid)
        disp_reg <= bcd;
      frame_tick <= 1'b0;
      if (cnt == last) begin
        cnt <= '0;
        case (state)
          BLANK_B:    begin state <= SHOW_UNITS; frame_tick <= 1'b1; end
          SHOW_UNITS: state <= BLANK_A;
          BLANK_A:    state <= SHOW_TENS;
          SHOW_TENS:  state <= BLANK_B;
          default:    state <= BLANK_B;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    an     = 2'b00;
    seg_ah = 7'h00;
    case (state)
      SHOW_UNITS: begin
        an     = 2'b01;
        seg_ah = enc[0];
      end
      SHOW_TENS: begin
        an     = 2'b10;
        seg_ah = ((BLANK_LZ != 0) && (dig[1] == 4'd0)) ? 7'h00 : enc[1];
      end
      default: ;
    endcase
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
  assign err = |nib_bad;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan: default instance plus a leading-zero-blank,
// active-low instance sharing the same stimulus.

module tb_bcd_7seg_scan;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bcd;
  logic       bcd_valid;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       err_a, err_b, ft_a, ft_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] lut [16];

  always #5 clk = ~clk;

  bcd_7seg_scan ua (
    .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid),
    .seg(seg_a), .an(an_a), .err(err_a), .frame_tick(ft_a)
  );

  bcd_7seg_scan #(.BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) ub (
    .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid),
    .seg(seg_b), .an(an_b), .err(err_b), .frame_tick(ft_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    bcd       = w;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
    bcd       = 8'hXX;
  endtask

  task automatic wait_ft(input string tag);
    int i;
    i = 0;
    while (ft_a !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, ".ft_seen"}, 8'(ft_a), 8'h01);
  endtask

  // Entered on the first SHOW_UNITS cycle; leaves on the first cycle of the next frame.
  task automatic frame_chk(input string tag, input bit b, input logic [6:0] su,
                           input logic [6:0] st, input logic [6:0] sb, input logic e);
    logic [1:0] ea;
    logic [6:0] es;
    for (int j = 0; j < 10; j++) begin
      ea = (j < 4) ? 2'b01 : (j >= 5 && j < 9) ? 2'b10 : 2'b00;
      es = (j < 4) ? su    : (j >= 5 && j < 9) ? st    : sb;
      chk($sformatf("%s.an[%0d]", tag, j),  8'(b ? an_b  : an_a),  8'(ea));
      chk($sformatf("%s.seg[%0d]", tag, j), 8'(b ? seg_b : seg_a), 8'(es));
      chk($sformatf("%s.err[%0d]", tag, j), 8'(b ? err_b : err_a), 8'(e));
      chk($sformatf("%s.ft[%0d]", tag, j),  8'(b ? ft_b  : ft_a),  8'(j == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [1:0] ea;
    logic [6:0] es;
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
    lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
    lut[8] = 7'h7F; lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) lut[i] = 7'h40;

    rst = 1'b1; bcd = 8'h00; bcd_valid = 1'b0;
    #2;
    chk("rst.an",    8'(an_a),  8'h00);
    chk("rst.seg",   8'(seg_a), 8'h00);
    chk("rst.err",   8'(err_a), 8'h00);
    chk("rst.ft",    8'(ft_a),  8'h00);
    chk("rst.seg_b", 8'(seg_b), 8'h7F);
    chk("rst.an_b",  8'(an_b),  8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cycle 0 is the single BLANK_B cycle before the first edge after release.
    chk("c0.an", 8'(an_a), 8'h00);
    chk("c0.ft", 8'(ft_a), 8'h00);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ea = (k == 5 || k == 10) ? 2'b00 : (k >= 6 && k <= 9) ? 2'b10 : 2'b01;
      es = (ea == 2'b00) ? 7'h00 : 7'h3F;
      chk($sformatf("boot.an[%0d]", k),  8'(an_a),  8'(ea));
      chk($sformatf("boot.seg[%0d]", k), 8'(seg_a), 8'(es));
      chk($sformatf("boot.ft[%0d]", k),  8'(ft_a),  8'(k == 1 || k == 11));
      chk($sformatf("boot.err[%0d]", k), 8'(err_a), 8'h00);
    end

    @(negedge clk);
    load(8'h15);
    wait_ft("l15");
    frame_chk("l15.f0", 1'b0, 7'h6D, 7'h06, 7'h00, 1'b0);
    frame_chk("l15.f1", 1'b0, 7'h6D, 7'h06, 7'h00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      w = {4'(i / 10), 4'(i % 10)};
      load(w);
      wait_ft($sformatf("sw%0d", i));
      frame_chk($sformatf("sw%0d", i), 1'b0, lut[i % 10], lut[i / 10], 7'h00, 1'b0);
    end

    load(8'h1C);
    chk("l1C.err_now", 8'(err_a), 8'h01);
    wait_ft("l1C");
    frame_chk("l1C", 1'b0, 7'h40, 7'h06, 7'h00, 1'b1);
    load(8'h07);
    chk("l07.err_next", 8'(err_a), 8'h00);
    wait_ft("l07");
    frame_chk("l07", 1'b0, 7'h07, 7'h3F, 7'h00, 1'b0);

    load(8'h03);
    wait_ft("b03");
    frame_chk("b03", 1'b1, 7'h30, 7'h7F, 7'h7F, 1'b0);
    load(8'h12);
    wait_ft("b12");
    frame_chk("b12", 1'b1, 7'h24, 7'h79, 7'h7F, 1'b0);

    // Reset in the middle of the tens phase, third cycle of SHOW_TENS.
    load(8'h14);
    wait_ft("r14");
    repeat (7) @(negedge clk);
    chk("r14.pre_an",  8'(an_a),  8'h02);
    chk("r14.pre_seg", 8'(seg_a), 8'h06);
    #1 rst = 1'b1;
    #1;
    chk("mid.an",    8'(an_a),  8'h00);
    chk("mid.seg",   8'(seg_a), 8'h00);
    chk("mid.err",   8'(err_a), 8'h00);
    chk("mid.ft",    8'(ft_a),  8'h00);
    chk("mid.seg_b", 8'(seg_b), 8'h7F);
    @(negedge clk);
    rst = 1'b0;
    chk("rel.c0_an", 8'(an_a), 8'h00);
    @(negedge clk);
    chk("rel.c1_ft", 8'(ft_a), 8'h01);
    frame_chk("rel", 1'b0, 7'h3F, 7'h3F, 7'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
